controller: RTL and testbench
=============================

Name: controller

Overview:
- Moore-style sequencing controller for the memory-to-memory transfer datapath.
- Fills memory A with A_WORDS words, then streams memory A out in pairs and writes one word per pair into memory B (A_WORDS/2 words).
- Drives address-counter increments (IncA, IncB) and write enables (WEA, WEB).
- Exposes present and next state for verification.
- Has no data inputs; the schedule is fixed.

Parameters:
- STATE_W, 5, width of the ps/ns state code.
- A_WORDS, 8, words written to memory A. Must be even. 2*A_WORDS+2 must not exceed 2^STATE_W. B_WORDS = A_WORDS/2.

Ports:
- clock  input  1  single system clock, rising-edge active.
- Reset  input  1  asynchronous, active-low reset.
- IncA  output  1  increment memory-A address counter.
- IncB  output  1  increment memory-B address counter.
- WEA  output  1  write enable, memory A.
- WEB  output  1  write enable, memory B.
- ps  output  STATE_W  present state code (registered).
- ns  output  STATE_W  next state code (combinational from ps).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset low: ps forced to 0 immediately, independent of clock. All four control outputs are 0 while ps=0.
- ps updates to ns on every rising clock edge while Reset is high.
- ns is purely combinational from ps. During reset ns = 1.
- Outputs are decoded from ps only (Moore); no glitch-free requirement beyond that.
- State codes and outputs:
  - S0 (0) IDLE: all outputs 0; ns=1 unconditionally.
  - S1..S8 (1..A_WORDS) FILL: WEA=1, IncA=1, WEB=0, IncB=0; ns=ps+1.
  - S9..S16 (A_WORDS+1..2*A_WORDS) XFER: IncA=1 every state, WEA=0.
    - Even-offset states, i.e. the second read of each pair (10, 12, 14, 16): WEB=1 and IncB=1.
    - Other XFER states: WEB=0, IncB=0.
    - ns=ps+1.
  - S17 (2*A_WORDS+1) DONE: all outputs 0; ns=17 (hold).
- Any unused code (18..31) decodes as DONE outputs (all 0) with ns=0 (recovery).
- WEA and WEB are never high in the same cycle.
- Exactly A_WORDS WEA pulses and B_WORDS WEB pulses occur per run.
- Reset asserted mid-run: immediate return to S0. The run restarts from S1 after release.
- Reset release timing: first edge after release moves ps 0->1.

Optional Feature:
- Macro CONTROLLER_LOOP_EN.
- Defined: DONE has ns=0, so the controller repeats fill/transfer indefinitely. Period is 2*A_WORDS+2 cycles.
- Undefined: DONE holds until reset, as above.

Decomposition:
- Shared package controller_pkg holds:
  - STATE_W default.
  - Named localparam state codes: S_IDLE, S_FILL_FIRST, S_FILL_LAST, S_XFER_FIRST, S_XFER_LAST, S_DONE.
  - An output-bundle typedef {IncA, IncB, WEA, WEB}.
- No sub-module needed. State register, next-state logic and output decode live in one module.

Test Plan:
- Reset high-to-low with clock toggling: ps=0, ns=1, IncA=IncB=WEA=WEB=0 while Reset=0.
- Release reset, count edges: ps steps 1..8 with WEA=IncA=1; exactly 8 WEA pulses; WEB=0 throughout.
- Continue: ps 9..16 with IncA=1 each cycle. WEB=IncB=1 only at ps=10, 12, 14, 16, giving 4 WEB pulses.
- Continue 5 more edges: ps stays 17, ns=17, all outputs 0. With CONTROLLER_LOOP_EN: ps goes 17->0->1 and the WEA pattern repeats.
- Assert Reset at ps=12 between edges: ps=0 and outputs 0 immediately, without waiting for a clock. After release, ps=1 on the next edge.
- Force ps to 25 (illegal code): outputs all 0, ns=0; next edge ps=0.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types and state codes for the memory-to-memory transfer controller.
// Codes below assume the default fill depth; the top re-derives them from its own A_WORDS.
package controller_pkg;

  localparam int unsigned STATE_W     = 5;
  localparam int unsigned A_WORDS_DEF = 8;

  localparam logic [STATE_W-1:0] S_IDLE       = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FILL_FIRST = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_FILL_LAST  = STATE_W'(A_WORDS_DEF);
  localparam logic [STATE_W-1:0] S_XFER_FIRST = STATE_W'(A_WORDS_DEF + 1);
  localparam logic [STATE_W-1:0] S_XFER_LAST  = STATE_W'(2 * A_WORDS_DEF);
  localparam logic [STATE_W-1:0] S_DONE       = STATE_W'(2 * A_WORDS_DEF + 1);

  typedef struct packed {
    logic inc_a;
    logic inc_b;
    logic wea;
    logic web;
  } ctrl_out_t;

endpackage

// File: rtl/controller.sv
// Moore sequencer: fills memory A, then streams A in pairs writing one word per pair into B.
// Define CONTROLLER_LOOP_EN to make DONE wrap back to IDLE and repeat the run forever.
module controller #(
  parameter int unsigned STATE_W = controller_pkg::STATE_W,
  parameter int unsigned A_WORDS = controller_pkg::A_WORDS_DEF
) (
  input  logic               clock,
  input  logic               Reset,
  output logic               IncA,
  output logic               IncB,
  output logic               WEA,
  output logic               WEB,
  output logic [STATE_W-1:0] ps,
  output logic [STATE_W-1:0] ns
);

  import controller_pkg::*;

  localparam logic [STATE_W-1:0] Idle      = STATE_W'(0);
  localparam logic [STATE_W-1:0] FillFirst = STATE_W'(1);
  localparam logic [STATE_W-1:0] FillLast  = STATE_W'(A_WORDS);
  localparam logic [STATE_W-1:0] XferFirst = STATE_W'(A_WORDS + 1);
  localparam logic [STATE_W-1:0] XferLast  = STATE_W'(2 * A_WORDS);
  localparam logic [STATE_W-1:0] Done      = STATE_W'(2 * A_WORDS + 1);

  logic [STATE_W-1:0] ps_q, ns_d, xfer_off;
  ctrl_out_t          out;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) ps_q <= Idle;
    else        ps_q <= ns_d;
  end

  always_comb begin
    ns_d = Idle;
    if (ps_q == Idle) begin
      ns_d = FillFirst;
    end else if (ps_q <= XferLast) begin
      ns_d = ps_q + STATE_W'(1);
    end else if (ps_q == Done) begin
`ifdef CONTROLLER_LOOP_EN
      ns_d = Idle;
`else
      ns_d = Done;
`endif
    end
  end

  // Even offset from the last fill state marks the second read of each pair.
  assign xfer_off = ps_q - FillLast;

  always_comb begin
    out = '0;
    if (ps_q >= FillFirst && ps_q <= FillLast) begin
      out.inc_a = 1'b1;
      out.wea   = 1'b1;
    end else if (ps_q >= XferFirst && ps_q <= XferLast) begin
      out.inc_a = 1'b1;
      if (!xfer_off[0]) begin
        out.inc_b = 1'b1;
        out.web   = 1'b1;
      end
    end
  end

  assign IncA = out.inc_a;
  assign IncB = out.inc_b;
  assign WEA  = out.wea;
  assign WEB  = out.web;
  assign ps   = ps_q;
  assign ns   = ns_d;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expected state/outputs queued per edge, popped after the edge.
// Honours CONTROLLER_LOOP_EN for the DONE successor.
module tb_controller;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned A_WORDS = 8;
  localparam int          DoneSt  = 2 * A_WORDS + 1;

  logic               clock = 1'b0;
  logic               Reset = 1'b0;
  logic               IncA, IncB, WEA, WEB;
  logic [STATE_W-1:0] ps, ns;

  controller #(
    .STATE_W (STATE_W),
    .A_WORDS (A_WORDS)
  ) dut (
    .clock (clock),
    .Reset (Reset),
    .IncA  (IncA),
    .IncB  (IncB),
    .WEA   (WEA),
    .WEB   (WEB),
    .ps    (ps),
    .ns    (ns)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         ps;
    int         ns;
    logic [3:0] outs;  // {IncA, IncB, WEA, WEB}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_ps;
  int   wea_cnt, web_cnt, both_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_next(input int p);
    if (p == 0) return 1;
    if (p <= 2 * A_WORDS) return p + 1;
`ifdef CONTROLLER_LOOP_EN
    if (p == DoneSt) return 0;
`else
    if (p == DoneSt) return DoneSt;
`endif
    return 0;
  endfunction

  function automatic logic [3:0] exp_outs(input int p);
    if (p >= 1 && p <= A_WORDS) return 4'b1010;
    if (p > A_WORDS && p <= 2 * A_WORDS) return ((p - A_WORDS) % 2 == 0) ? 4'b1101 : 4'b1000;
    return 4'b0000;
  endfunction

  task automatic push_exp(input int p);
    exp_t e;
    e.ps   = p;
    e.ns   = exp_next(p);
    e.outs = exp_outs(p);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, "_ps"}, 32'(ps), 32'(e.ps));
    check_eq({tag, "_ns"}, 32'(ns), 32'(e.ns));
    check_eq({tag, "_outs"}, 32'({IncA, IncB, WEA, WEB}), 32'(e.outs));
  endtask

  task automatic step(input string tag);
    exp_ps = exp_next(exp_ps);
    push_exp(exp_ps);
    @(posedge clock);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held while the clock runs.
    repeat (3) begin
      @(negedge clock);
      push_exp(0);
      pop_check("reset");
    end

    // Full run from release.
    @(negedge clock);
    Reset   = 1'b1;
    exp_ps  = 0;
    wea_cnt = 0;
    web_cnt = 0;
    both_cnt = 0;
    for (int i = 0; i < 2 * A_WORDS + 1; i++) begin
      step("run");
      if (WEA === 1'b1) wea_cnt++;
      if (WEB === 1'b1) web_cnt++;
      if (WEA === 1'b1 && WEB === 1'b1) both_cnt++;
    end
    check_eq("wea_pulses", 32'(wea_cnt), 32'(A_WORDS));
    check_eq("web_pulses", 32'(web_cnt), 32'(A_WORDS / 2));
    check_eq("we_overlap", 32'(both_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step("after_done");

    // Asynchronous reset mid-run at ps=12.
    @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);
    Reset  = 1'b1;
    exp_ps = 0;
    for (int i = 0; i < 12; i++) step("to12");
    #1;
    Reset = 1'b0;
    #1;
    push_exp(0);
    pop_check("async_rst");
    @(negedge clock);
    Reset  = 1'b1;
    exp_ps = 0;
    step("post_rst");
    step("post_rst2");

    // Illegal code recovers through IDLE.
    @(negedge clock);
    force dut.ps_q = 5'd25;
    #1;
    push_exp(25);
    pop_check("illegal");
    release dut.ps_q;
    exp_ps = 25;
    step("recover");
    step("recover2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
